// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, packs dibits LSB-first into bytes and
// emits them one byte-time late so end-of-frame and error status ride on the last byte.
module rmii_rx_deframer #(
  parameter int unsigned SAMPLE_10M_PHASE = 4
) (
  input  logic       phy_ref_clk,
  input  logic       phy_rst_n,
  input  logic       speed_100,
  input  logic [1:0] phy_rxd,
  input  logic       phy_crs_dv,
  input  logic       phy_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_rx_bad_frame,
  output logic       stat_rx_false_carrier
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPreamble = 2'd1;
  localparam logic [1:0] StData     = 2'd2;

  localparam logic [3:0] Phase10M = 4'(SAMPLE_10M_PHASE);

  logic [1:0] r_state;
  logic       r_speed_100;
  logic [3:0] r_cnt10;
  logic       r_crs_dv_q;
  logic [1:0] r_idx;
  logic [5:0] r_shift;
  logic       r_err;
  logic       r_have_held;
  logic [7:0] r_held;
  logic [7:0] r_tdata;
  logic       r_tvalid;
  logic       r_tlast;
  logic       r_tuser;
  logic       r_bad;
  logic       r_fc;

  logic [1:0] w_state_nxt;
  logic       w_speed_nxt;
  logic [3:0] w_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_speed;
  logic       w_sample;
  logic       w_end;
  logic [7:0] w_byte;
  logic [1:0] w_idx_nxt;
  logic [5:0] w_shift_nxt;
  logic       w_err_nxt;
  logic       w_have_nxt;
  logic [7:0] w_held_nxt;
  logic [7:0] w_data_nxt;
  logic       w_valid_nxt;
  logic       w_last_nxt;
  logic       w_user_nxt;
  logic       w_fc_nxt;

  // 10M phase counter realigns to the first clock of carrier while idle.
  assign w_cnt     = (r_state == StIdle && phy_crs_dv && !r_crs_dv_q) ? 4'd0 : r_cnt10;
  assign w_cnt_nxt = (w_cnt == 4'd9) ? 4'd0 : w_cnt + 4'd1;
  assign w_speed   = (r_state == StIdle) ? speed_100 : r_speed_100;
  assign w_sample  = w_speed || (w_cnt == Phase10M);
  // Carrier loss only ends the frame at the second dibit of a nibble.
  assign w_end     = !phy_crs_dv && r_idx[0];
  assign w_byte    = {phy_rxd, r_shift};

  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed_100;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_err_nxt   = r_err;
    w_have_nxt  = r_have_held;
    w_held_nxt  = r_held;
    w_data_nxt  = 8'h00;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_user_nxt  = 1'b0;
    w_fc_nxt    = 1'b0;
    if (w_sample) begin
      case (r_state)
        StIdle: begin
          if (phy_rx_er && phy_rxd == 2'b10) begin
            w_fc_nxt = 1'b1;
          end else if (phy_crs_dv && phy_rxd == 2'b01) begin
            w_state_nxt = StPreamble;
            w_speed_nxt = speed_100;
          end
        end
        StPreamble: begin
          if (!phy_crs_dv || !phy_rxd[0]) begin
            w_state_nxt = StIdle;
          end else if (phy_rxd == 2'b11) begin
            w_state_nxt = StData;
            w_idx_nxt   = 2'd0;
            w_err_nxt   = 1'b0;
            w_have_nxt  = 1'b0;
          end
        end
        StData: begin
          if (w_end) begin
            w_state_nxt = StIdle;
            w_have_nxt  = 1'b0;
            if (r_have_held) begin
              w_valid_nxt = 1'b1;
              w_data_nxt  = r_held;
              w_last_nxt  = 1'b1;
              // Ending at index 3 leaves a nibble plus one dibit: alignment error.
              w_user_nxt  = r_err || r_idx[1];
            end
          end else begin
            if (phy_crs_dv && phy_rx_er) w_err_nxt = 1'b1;
            w_idx_nxt = r_idx + 2'd1;
            case (r_idx)
              2'd0:    w_shift_nxt[1:0] = phy_rxd;
              2'd1:    w_shift_nxt[3:2] = phy_rxd;
              2'd2:    w_shift_nxt[5:4] = phy_rxd;
              default: begin
                if (r_have_held) begin
                  w_valid_nxt = 1'b1;
                  w_data_nxt  = r_held;
                end
                w_held_nxt = w_byte;
                w_have_nxt = 1'b1;
              end
            endcase
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge phy_ref_clk or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      r_state     <= StIdle;
      r_speed_100 <= 1'b0;
      r_cnt10     <= 4'd0;
      r_crs_dv_q  <= 1'b0;
      r_idx       <= 2'd0;
      r_shift     <= 6'd0;
      r_err       <= 1'b0;
      r_have_held <= 1'b0;
      r_held      <= 8'h00;
      r_tdata     <= 8'h00;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_bad       <= 1'b0;
      r_fc        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_speed_100 <= w_speed_nxt;
      r_cnt10     <= w_cnt_nxt;
      r_crs_dv_q  <= phy_crs_dv;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_err       <= w_err_nxt;
      r_have_held <= w_have_nxt;
      r_held      <= w_held_nxt;
      r_tdata     <= w_data_nxt;
      r_tvalid    <= w_valid_nxt;
      r_tlast     <= w_last_nxt;
      r_tuser     <= w_user_nxt;
      r_bad       <= w_last_nxt && w_user_nxt;
      r_fc        <= w_fc_nxt;
    end
  end

  assign m_axis_tdata          = r_tdata;
  assign m_axis_tvalid         = r_tvalid;
  assign m_axis_tlast          = r_tlast;
  assign m_axis_tuser          = r_tuser;
  assign stat_rx_bad_frame     = r_bad;
  assign stat_rx_false_carrier = r_fc;

endmodule
